// File: rtl/shared_bus_pkg.sv
// Shared definitions for the tri-state bus arbiter: FSM encoding, counter widths
// and the owner-index width helper.
package shared_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    localparam int DEFAULT_N = 4;
    localparam int BURST_W   = 8;
    localparam int TURN_W    = 4;

    function automatic int owner_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEFAULT_OWNER_W = owner_width(DEFAULT_N);

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request scanning last+1, last+2, ... mod N.
module rr_priority_pick
    import shared_bus_pkg::*;
#(
    parameter  int N  = 4,
    localparam int OW = owner_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [OW-1:0] last,
    output logic          valid,
    output logic [OW-1:0] winner,
    output logic [N-1:0]  onehot
);

    int idx;

    // NOTE: every output gets a default before the scan so no latch is inferred.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        onehot = '0;
        idx    = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = OW'(idx);
            end
        end
        if (valid) begin
            onehot[winner] = 1'b1;
        end
    end

endmodule

// File: rtl/shared_bus_arbiter.sv
// Round-robin owner of a shared tri-state bus: one-hot registered enables, burst cap,
// and an all-off turnaround gap between owners.
module shared_bus_arbiter
    import shared_bus_pkg::*;
#(
    parameter  int N         = 4,
    parameter  int MAX_BURST = 8,
    parameter  int TA_CYCLES = 1,
    localparam int OW        = owner_width(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       req,
    output logic [N-1:0]       gnt,
    output logic [OW-1:0]      owner,
    output logic               busy,
    output logic [BURST_W-1:0] burst_cnt
);

    localparam logic [BURST_W-1:0] BURST_MAX  = BURST_W'(MAX_BURST);
    localparam logic [TURN_W-1:0]  TURN_LOAD  = TURN_W'(TA_CYCLES);
    localparam logic [TURN_W-1:0]  TURN_LAST  = TURN_W'(1);
    localparam logic [OW-1:0]      LAST_RESET = OW'(N - 1);

    state_t            state;
    logic [OW-1:0]     last;
    logic [TURN_W-1:0] turn_cnt;
    logic              pick_valid;
    logic [OW-1:0]     pick_idx;
    logic [N-1:0]      pick_onehot;

    rr_priority_pick #(.N(N)) u_pick (
        .req    (req),
        .last   (last),
        .valid  (pick_valid),
        .winner (pick_idx),
        .onehot (pick_onehot)
    );

    // NOTE: all state updates use non-blocking assignments so every register
    // sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            busy      <= 1'b0;
            owner     <= '0;
            burst_cnt <= '0;
            last      <= LAST_RESET;
            turn_cnt  <= '0;
        end else begin
            unique case (state)
                GRANT: begin
                    if (req[owner] && (burst_cnt < BURST_MAX)) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end else begin
                        // Release: enables drop now, the gap starts next cycle.
                        state     <= TURN;
                        gnt       <= '0;
                        busy      <= 1'b0;
                        burst_cnt <= '0;
                        last      <= owner;
                        turn_cnt  <= TURN_LOAD;
                    end
                end
                IDLE, TURN: begin
                    if ((state == TURN) && (turn_cnt != TURN_LAST)) begin
                        turn_cnt <= turn_cnt - 1'b1;
                    end else if (pick_valid) begin
                        state     <= GRANT;
                        gnt       <= pick_onehot;
                        busy      <= 1'b1;
                        owner     <= pick_idx;
                        burst_cnt <= BURST_W'(1);
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Directed and randomized bench for shared_bus_arbiter against a cycle-level reference model.
`timescale 1ns/1ps
module tb_shared_bus_arbiter;

    localparam int N         = 4;
    localparam int MAX_BURST = 8;
    localparam int TA_CYCLES = 1;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [1:0]   owner;
    logic         busy;
    logic [7:0]   burst_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: who holds the bus, for how long, and how much gap remains.
    bit m_active;
    int m_own;
    int m_cnt;
    int m_gap;
    int m_last;

    shared_bus_arbiter #(
        .N         (N),
        .MAX_BURST (MAX_BURST),
        .TA_CYCLES (TA_CYCLES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .owner     (owner),
        .busy      (busy),
        .burst_cnt (burst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_arbitrate();
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (m_last + k) % N;
            if (req[idx]) begin
                m_active = 1'b1;
                m_own    = idx;
                m_cnt    = 1;
                return;
            end
        end
    endtask

    task automatic model_step();
        if (!rst_n) begin
            m_active = 1'b0;
            m_own    = 0;
            m_cnt    = 0;
            m_gap    = 0;
            m_last   = N - 1;
        end else if (m_active) begin
            if (req[m_own] && m_cnt < MAX_BURST) begin
                m_cnt++;
            end else begin
                m_active = 1'b0;
                m_cnt    = 0;
                m_last   = m_own;
                m_gap    = TA_CYCLES;
            end
        end else if (m_gap > 0) begin
            m_gap--;
            if (m_gap == 0) model_arbitrate();
        end else begin
            model_arbitrate();
        end
    endtask

    // One clock: model follows the same edge, outputs compared 1ns after it.
    task automatic cycle();
        logic [N-1:0] exp_gnt;
        @(posedge clk);
        model_step();
        #1;
        exp_gnt = m_active ? (N'(1) << m_own) : '0;
        check("model_gnt", 32'(gnt), 32'(exp_gnt));
        check("model_owner", 32'(owner), 32'(m_own));
        check("model_busy", 32'(busy), 32'(m_active));
        check("model_burst", 32'(burst_cnt), 32'(m_cnt));
        check("onehot0", 32'($onehot0(gnt)), 32'(1));
    endtask

    task automatic do_reset(input logic [N-1:0] r, input int edges);
        rst_n = 1'b0;
        req   = r;
        for (int i = 0; i < edges; i++) cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] exp;
        rst_n = 1'b0;
        req   = '1;

        // Reset with all requests high, then first grant goes to requester 0.
        do_reset(4'b1111, 2);
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_owner", 32'(owner), 32'h0);
        check("rst_burst", 32'(burst_cnt), 32'h0);
        cycle();
        check("first_grant", 32'(gnt), 32'b0001);

        // Single requester held: 8 on, 1 off, 8 on.
        do_reset(4'b0100, 1);
        for (int c = 1; c <= 17; c++) begin
            cycle();
            exp = (c % 9 != 0) ? 4'b0100 : 4'b0000;
            check($sformatf("hold2_c%0d", c), 32'(gnt), 32'(exp));
        end

        // All requesting: rotate 0,1,2,3,0 with 1-cycle gaps.
        do_reset(4'b1111, 1);
        for (int c = 1; c <= 44; c++) begin
            int slot;
            int pos;
            cycle();
            slot = (c - 1) / 9;
            pos  = (c - 1) % 9;
            exp  = (pos < 8) ? (4'b0001 << (slot % 4)) : 4'b0000;
            check($sformatf("rr_c%0d", c), 32'(gnt), 32'(exp));
        end

        // Early drop: owner 0 releases after its 4th grant cycle.
        do_reset(4'b0101, 1);
        for (int c = 1; c <= 4; c++) begin
            cycle();
            check($sformatf("drop_c%0d", c), 32'(gnt), 32'b0001);
        end
        req = 4'b0100;
        cycle();
        check("drop_gap", 32'(gnt), 32'h0);
        cycle();
        check("drop_next_gnt", 32'(gnt), 32'b0100);
        check("drop_next_burst", 32'(burst_cnt), 32'h1);

        // Drop coinciding with the burst cap: one gap only.
        do_reset(4'b0011, 1);
        for (int c = 1; c <= 8; c++) cycle();
        check("coin_burst8", 32'(burst_cnt), 32'h8);
        req = 4'b0010;
        cycle();
        check("coin_gap", 32'(gnt), 32'h0);
        cycle();
        check("coin_next", 32'(gnt), 32'b0010);

        // Reset in the middle of a grant.
        do_reset(4'b0100, 1);
        for (int c = 1; c <= 5; c++) cycle();
        check("mid_pre_burst", 32'(burst_cnt), 32'h5);
        check("mid_pre_owner", 32'(owner), 32'h2);
        rst_n = 1'b0;
        cycle();
        check("mid_rst_gnt", 32'(gnt), 32'h0);
        check("mid_rst_owner", 32'(owner), 32'h0);
        check("mid_rst_burst", 32'(burst_cnt), 32'h0);
        rst_n = 1'b1;
        req   = 4'b1111;
        cycle();
        check("mid_after_gnt", 32'(gnt), 32'b0001);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 15));
            rst_n = ($urandom_range(0, 79) != 0);
            cycle();
        end
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
